// File: rtl/imm_encode_loader_pkg.sv
// imm_encode_loader_pkg: shared ImmSrc codes, NOP word, loader FSM states and range helper
package imm_encode_loader_pkg;
  localparam logic [1:0] IMMSRC_I = 2'b00;
  localparam logic [1:0] IMMSRC_S = 2'b01;
  localparam logic [1:0] IMMSRC_B = 2'b10;
  localparam logic [1:0] IMMSRC_J = 2'b11;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  // true when v is representable as an n-bit two's-complement value
  function automatic logic fits(logic [31:0] v, int n);
    logic [31:0] t;
    t = $signed(v) >>> (n - 1);
    return &t | ~|t;
  endfunction
endpackage

// File: rtl/imm_encode_loader_if.sv
// imm_encode_loader_if: burst control, encode request channel, instr-memory write port and status
//  master: program source / bench side; slave: the loader
interface imm_encode_loader_if #(parameter int ADDR_W = 10, parameter int CNT_W = 11);
  logic start;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0] length;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic [1:0] in_immsrc;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic busy;
  logic done;
  logic err;
  logic [CNT_W-1:0] err_cnt;
  modport master(
    output start, start_addr, length, in_valid, in_base, in_imm, in_immsrc,
    input in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_cnt
  );
  modport slave(
    input start, start_addr, length, in_valid, in_base, in_imm, in_immsrc,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_cnt
  );
endinterface

// File: rtl/imm_encode_loader_imm_pack.sv
// imm_pack: places a signed immediate into the I/S/B/J fields of base and flags range/alignment
//  in: base (instr word), imm (signed immediate), immsrc (core ImmSrc)
//  out: word (base with immediate fields replaced), legal (imm encodable for immsrc)
module imm_pack
  import imm_encode_loader_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [1:0]  immsrc,
  output logic [31:0] word,
  output logic        legal
);
  always_comb begin
    word = immsrc == IMMSRC_I ? {imm[11:0], base[19:0]} :
           immsrc == IMMSRC_S ? {imm[11:5], base[24:12], imm[4:0], base[6:0]} :
           immsrc == IMMSRC_B ? {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]} :
                                {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
    // B/J targets are halfword offsets, so bit 0 is never encoded and must be zero
    legal = immsrc == IMMSRC_I || immsrc == IMMSRC_S ? fits(imm, 12) :
            immsrc == IMMSRC_B ? fits(imm, 13) && !imm[0] :
                                 fits(imm, 21) && !imm[0];
  end
endmodule

// File: rtl/imm_encode_loader.sv
// imm_encode_loader: encodes immediates into instruction words and streams them into instr memory
//  clk, rst_n (async active-low)
//  bus (slave): start/start_addr/length burst control, in_* request handshake,
//   mem_we/mem_addr/mem_wdata write port, busy/done/err/err_cnt status
module imm_encode_loader
  import imm_encode_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 11
) (
  input logic clk,
  input logic rst_n,
  imm_encode_loader_if.slave bus
);
  state_t state, next;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0] left;
  logic [31:0] word;
  logic legal;
  logic accept;
  imm_pack u_pack (
    .base(bus.in_base),
    .imm(bus.in_imm),
    .immsrc(bus.in_immsrc),
    .word(word),
    .legal(legal)
  );
  assign bus.in_ready = state == LOAD && left != '0;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign accept = bus.in_valid && bus.in_ready;
  // leaving LOAD once beats run out lets the last write occupy its cycle before DONE
  always_comb begin
    next = state == IDLE ? (bus.start ? (bus.length != '0 ? LOAD : DONE) : IDLE) :
           state == LOAD ? (left == '0 ? DONE : LOAD) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      left <= '0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.err <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      bus.mem_we <= accept;
      if (state == IDLE && bus.start) begin
        ptr <= bus.start_addr;
        left <= bus.length;
        bus.err <= 1'b0;
        bus.err_cnt <= '0;
      end
      if (accept) begin
        bus.mem_addr <= ptr;
        bus.mem_wdata <= legal ? word : INSTR_NOP;
        ptr <= ptr + 1'b1;
        left <= left - 1'b1;
        if (!legal) begin
          bus.err <= 1'b1;
          bus.err_cnt <= &bus.err_cnt ? bus.err_cnt : bus.err_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_imm_encode_loader.sv
// tb_imm_encode_loader: scoreboard bench with a range-based reference model and a decoding monitor
module tb_imm_encode_loader;
  import imm_encode_loader_pkg::*;
  localparam int AW = 10;
  localparam int CW = 11;
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0] word;
    logic [31:0] imm;
    logic [1:0] src;
    logic legal;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int fails = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  logic [31:0] last_word = '0;
  always #5 clk = ~clk;
  imm_encode_loader_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();
  imm_encode_loader #(.ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_legal(logic [31:0] imm, logic [1:0] src);
    int v;
    v = imm;
    if (src == 2'd0 || src == 2'd1) return v >= -2048 && v <= 2047;
    if (src == 2'd2) return v >= -4096 && v <= 4094 && v % 2 == 0;
    return v >= -1048576 && v <= 1048574 && v % 2 == 0;
  endfunction

  function automatic logic [31:0] m_encode(logic [31:0] base, logic [31:0] imm, logic [1:0] src);
    logic [31:0] e;
    e = base;
    case (src)
      2'd0: e[31:20] = imm[11:0];
      2'd1: begin e[31:25] = imm[11:5]; e[11:7] = imm[4:0]; end
      2'd2: begin e[31] = imm[12]; e[30:25] = imm[10:5]; e[11:8] = imm[4:1]; e[7] = imm[11]; end
      default: begin e[31] = imm[20]; e[30:21] = imm[10:1]; e[20] = imm[11]; e[19:12] = imm[19:12]; end
    endcase
    return e;
  endfunction

  // the core's immediate extender, used to confirm a legal word decodes back to its immediate
  function automatic logic [31:0] extend(logic [31:0] w, logic [1:0] src);
    case (src)
      2'd0: return {{20{w[31]}}, w[31:20]};
      2'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
      2'd2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] rand_imm();
    int b[8];
    b = '{2047, 2048, -2048, -2049, 4094, -4096, 1048574, -1048576};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
      default: return b[$urandom_range(0, 7)];
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      if (q.size() == 0) check("unexpected_write", {63'b0, bus.mem_we}, 64'd0);
      else begin
        mon_e = q.pop_front();
        check("mem_addr", bus.mem_addr, mon_e.addr);
        check("mem_wdata", bus.mem_wdata, mon_e.word);
        if (mon_e.legal) check("round_trip", extend(bus.mem_wdata, mon_e.src), mon_e.imm);
      end
      last_word = bus.mem_wdata;
    end
  end

  task automatic check_zero(string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_mem_we"}, bus.mem_we, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_err_cnt"}, bus.err_cnt, 0);
  endtask

  task automatic start_burst(int addr, int len);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.start_addr = AW'(addr);
    bus.length = CW'(len);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    m_ptr = addr;
    m_cnt = 0;
  endtask

  task automatic send_beat(logic [31:0] base, logic [31:0] imm, logic [1:0] src, int gap);
    bit acc;
    logic lg;
    acc = 0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.in_base = base;
    bus.in_imm = imm;
    bus.in_immsrc = src;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
    else begin
      lg = m_legal(imm, src);
      q.push_back('{AW'(m_ptr), lg ? m_encode(base, imm, src) : INSTR_NOP, imm, src, lg});
      m_ptr = (m_ptr + 1) % (1 << AW);
      if (!lg && m_cnt < (1 << CW) - 1) m_cnt++;
    end
  endtask

  task automatic finish_burst(string tag, output int waited);
    bit seen;
    seen = 0;
    waited = 0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      waited++;
      seen = bus.done;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_err"}, bus.err, m_cnt != 0);
    check({tag, "_err_cnt"}, bus.err_cnt, m_cnt);
    check({tag, "_drained"}, q.size(), 0);
    @(negedge clk);
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    bus.start = 0;
    bus.start_addr = '0;
    bus.length = '0;
    bus.in_valid = 0;
    bus.in_base = '0;
    bus.in_imm = '0;
    bus.in_immsrc = '0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // 1: single I beat, done follows the write by one cycle
    start_burst(0, 1);
    send_beat(32'h0000_0013, 32'hFFFF_FFFF, IMMSRC_I, 0);
    finish_burst("t1", w);
    check("t1_done_latency", w, 2);
    check("t1_word", last_word, 32'hFFF0_0013);
    // 2: extreme legal values for S/B/J
    start_burst(16, 3);
    send_beat(32'h0000_2023, 32'd2047, IMMSRC_S, 0);
    send_beat(32'h0000_0063, -32'sd4096, IMMSRC_B, 0);
    send_beat(32'h0000_00EF, 32'd1048574, IMMSRC_J, 0);
    finish_burst("t2", w);
    // 3: misaligned B and out-of-range I become NOPs and count as errors
    start_burst(40, 3);
    send_beat(32'h0000_0063, 32'd3, IMMSRC_B, 0);
    send_beat(32'h0000_0093, 32'd5, IMMSRC_I, 0);
    send_beat(32'h0000_0093, 32'd2048, IMMSRC_I, 0);
    finish_burst("t3", w);
    check("t3_err_cnt_2", bus.err_cnt, 2);
    // 4: address wrap with gaps on in_valid
    start_burst((1 << AW) - 1, 3);
    send_beat(32'h0000_0013, 32'd1, IMMSRC_I, 0);
    send_beat(32'h0000_0013, 32'd2, IMMSRC_I, 2);
    send_beat(32'h0000_0013, 32'd3, IMMSRC_I, 3);
    finish_burst("t4", w);
    check("t4_last_addr", bus.mem_addr, 1);
    // 5a: zero-length burst
    start_burst(77, 0);
    finish_burst("t5a", w);
    check("t5a_done_latency", w, 1);
    // 5b: start while loading is ignored
    start_burst(100, 2);
    send_beat(32'h0000_0063, 32'd1, IMMSRC_B, 0);
    bus.start = 1'b1;
    bus.start_addr = AW'(500);
    bus.length = CW'(7);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    send_beat(32'h0000_0013, 32'd100, IMMSRC_I, 0);
    finish_burst("t5b", w);
    // 6: reset mid-burst, then a fresh burst
    start_burst(200, 4);
    send_beat(32'h0000_0013, 32'd9999, IMMSRC_I, 0);
    send_beat(32'h0000_0013, 32'd7, IMMSRC_I, 0);
    rst_n = 1'b0;
    #1;
    check_zero("t6_reset");
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_burst(300, 2);
    send_beat(32'h0000_0013, 32'd42, IMMSRC_I, 0);
    send_beat(32'h0000_2023, -32'sd1, IMMSRC_S, 1);
    finish_burst("t6", w);
    // random bursts
    for (int b = 0; b < 8; b++) begin
      int len;
      len = $urandom_range(1, 8);
      start_burst($urandom_range(0, (1 << AW) - 1), len);
      for (int i = 0; i < len; i++)
        send_beat($urandom, rand_imm(), 2'($urandom_range(0, 3)), $urandom_range(0, 2));
      finish_burst("rand", w);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
